// File: rtl/muxsel_arbiter.sv
// muxsel_arbiter
// Round-robin arbiter that shares one Muxparam instance among 2**SEL
// requesters. It grants one requester at a time, drives the mux select with
// the owner's index, and forces a release after MAX_HOLD consecutive grant
// cycles so that no requester can monopolise the shared bus.
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst_n     - asynchronous active-low reset
//   req       - per-requester request levels (N = 2**SEL bits)
//   gnt       - one-hot grant, zero when no grant is valid
//   selec     - index of the current or last owner (to Muxparam.selec)
//   valid     - high while a grant is active
//   preempt   - one-cycle pulse in the dead cycle after a forced release
//   dbg_state - FSM state (0 = IDLE, 1 = GRANT)
//
// Handshake: req[i] is a level held by requester i for as long as it wants
// the bus. A grant is visible one cycle after the request is first sampled
// and drops one cycle after req[owner] is sampled low (or at MAX_HOLD).
// Every grant is followed by at least one IDLE cycle.
module muxsel_arbiter #(
  parameter int SEL      = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [(1<<SEL)-1:0]   req,
  output logic [(1<<SEL)-1:0]   gnt,
  output logic [SEL-1:0]        selec,
  output logic                  valid,
  output logic                  preempt,
  output logic                  dbg_state
);

  localparam int N  = 1 << SEL;
  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  state_t          r_state;
  logic [SEL-1:0]  r_ptr;
  logic [SEL-1:0]  r_owner;
  logic [CW-1:0]   r_cnt;
  logic            r_preempt;
  logic            r_valid;
  logic [N-1:0]    r_gnt;

  state_t          w_state_nxt;
  logic [SEL-1:0]  w_ptr_nxt;
  logic [SEL-1:0]  w_owner_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_preempt_nxt;

  logic            w_found;
  logic [SEL-1:0]  w_pick;
  logic [SEL-1:0]  w_scan_idx;

  // Rotating scan: first set request at or above r_ptr, wrapping N-1 -> 0.
  // The SEL-bit add wraps modulo N by construction.
  always_comb begin
    w_found    = 1'b0;
    w_pick     = '0;
    w_scan_idx = '0;
    for (int i = 0; i < N; i++) begin
      w_scan_idx = r_ptr + SEL'(i);
      if (!w_found && req[w_scan_idx]) begin
        w_found = 1'b1;
        w_pick  = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_cnt_nxt     = r_cnt;
    w_preempt_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_pick;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        // Normal release has priority over the hold limit, so a requester
        // that drops exactly at MAX_HOLD is not flagged as preempted.
        if (!req[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_owner + 1'b1;
        end else if (r_cnt == MAX_C) begin
          w_state_nxt   = S_IDLE;
          w_ptr_nxt     = r_owner + 1'b1;
          w_preempt_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_preempt <= 1'b0;
      r_valid   <= 1'b0;
      r_gnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_preempt <= w_preempt_nxt;
      // Grant outputs are registered from next-state so nothing on the
      // output side depends combinationally on req.
      r_valid   <= (w_state_nxt == S_GRANT);
      r_gnt     <= (w_state_nxt == S_GRANT) ? (N'(1) << w_owner_nxt) : '0;
    end
  end

  // selec follows the owner register, which only changes when entering
  // GRANT, so it holds the last owner through IDLE.
  assign gnt       = r_gnt;
  assign valid     = r_valid;
  assign selec     = r_owner;
  assign preempt   = r_preempt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muxsel_arbiter.sv
module tb_muxsel_arbiter;

  logic        clk;
  logic        rst_n;

  // Instance A: SEL=4, MAX_HOLD=3
  logic [15:0] req_a;
  logic [15:0] gnt_a;
  logic [3:0]  selec_a;
  logic        valid_a, preempt_a, state_a;

  // Instance B: SEL=2, MAX_HOLD=1
  logic [3:0]  req_b;
  logic [3:0]  gnt_b;
  logic [1:0]  selec_b;
  logic        valid_b, preempt_b, state_b;

  // Behavioural stand-in for Muxparam: distinct data per index
  logic [7:0]  mux_in [16];
  logic [7:0]  mux_out;

  int total;
  int bad;

  muxsel_arbiter #(.SEL(4), .MAX_HOLD(3)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .selec(selec_a),
    .valid(valid_a), .preempt(preempt_a), .dbg_state(state_a)
  );

  muxsel_arbiter #(.SEL(2), .MAX_HOLD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .selec(selec_b),
    .valid(valid_b), .preempt(preempt_b), .dbg_state(state_b)
  );

  assign mux_out = mux_in[selec_a];

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    if ({gnt_a, valid_a, selec_a, preempt_a} !== 22'd0) begin
      bad++;
      $display("FAIL reset_hold got gnt=%h v=%b sel=%0d p=%b exp all 0", gnt_a, valid_a, selec_a, preempt_a);
    end
    total++;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if ({gnt_a, valid_a, selec_a, preempt_a} !== 22'd0 ||
          {gnt_b, valid_b, selec_b, preempt_b} !== 8'd0) begin
        bad++;
        $display("FAIL idle_after_reset c%0d got gnt=%h v=%b sel=%0d p=%b exp all 0", c, gnt_a, valid_a, selec_a, preempt_a);
      end
      total++;
    end
  endtask

  task automatic test_single();
    req_a = 16'h0004;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (gnt_a !== 16'h0004 || selec_a !== 4'd2 || valid_a !== 1'b1 || preempt_a !== 1'b0) begin
        bad++;
        $display("FAIL single_grant c%0d got gnt=%h sel=%0d v=%b p=%b exp 0004/2/1/0", c, gnt_a, selec_a, valid_a, preempt_a);
      end
      total++;
    end
    req_a = '0;
    tick();
    if (gnt_a !== 16'h0 || valid_a !== 1'b0 || selec_a !== 4'd2 || preempt_a !== 1'b0) begin
      bad++;
      $display("FAIL single_release got gnt=%h v=%b sel=%0d p=%b exp 0/0/2/0", gnt_a, valid_a, selec_a, preempt_a);
    end
    total++;
    tick();
    if (valid_a !== 1'b0 || selec_a !== 4'd2) begin
      bad++;
      $display("FAIL single_idle_hold got v=%b sel=%0d exp 0/2", valid_a, selec_a);
    end
    total++;
  endtask

  // ptr is 3 here; scan 3..15,0 picks 0 first, then 0 and 2 alternate.
  task automatic test_preempt_rotation();
    int exp_own [12] = '{0, 0, 0, -1, 2, 2, 2, -1, 0, 0, 0, -1};
    int last;
    int run;
    last = 0;
    run  = 0;
    req_a = 16'h0005;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (exp_own[c] >= 0) begin
        last = exp_own[c];
        if (gnt_a !== (16'h1 << last) || valid_a !== 1'b1 || selec_a !== 4'(last) ||
            preempt_a !== 1'b0 || mux_out !== (8'hA0 + 8'(last))) begin
          bad++;
          $display("FAIL rot_grant c%0d got gnt=%h v=%b sel=%0d p=%b out=%h exp owner %0d", c, gnt_a, valid_a, selec_a, preempt_a, mux_out, last);
        end
      end else begin
        if (gnt_a !== 16'h0 || valid_a !== 1'b0 || preempt_a !== 1'b1 || selec_a !== 4'(last)) begin
          bad++;
          $display("FAIL rot_idle c%0d got gnt=%h v=%b p=%b sel=%0d exp 0/0/1/%0d", c, gnt_a, valid_a, preempt_a, selec_a, last);
        end
      end
      total++;
      run = valid_a ? run + 1 : 0;
      if (run > 3) begin
        bad++;
        $display("FAIL rot_max_run got=%0d exp<=3", run);
      end
      total++;
    end
    req_a = '0;
    tick();
    if (valid_a !== 1'b0 || preempt_a !== 1'b0) begin
      bad++;
      $display("FAIL rot_quiet got v=%b p=%b exp 0/0", valid_a, preempt_a);
    end
    total++;
  endtask

  // ptr is 1 here.
  task automatic test_wrap();
    req_a = 16'h4000;
    tick();
    if (selec_a !== 4'd14 || gnt_a !== 16'h4000) begin
      bad++;
      $display("FAIL wrap_14 got sel=%0d gnt=%h exp 14/4000", selec_a, gnt_a);
    end
    total++;
    req_a = '0;
    tick();
    req_a = 16'h8001;
    tick();
    if (selec_a !== 4'd15 || gnt_a !== 16'h8000) begin
      bad++;
      $display("FAIL wrap_15 got sel=%0d gnt=%h exp 15/8000", selec_a, gnt_a);
    end
    total++;
    req_a = 16'h0001;
    tick();
    if (valid_a !== 1'b0 || preempt_a !== 1'b0 || selec_a !== 4'd15) begin
      bad++;
      $display("FAIL wrap_dead got v=%b p=%b sel=%0d exp 0/0/15", valid_a, preempt_a, selec_a);
    end
    total++;
    tick();
    if (selec_a !== 4'd0 || gnt_a !== 16'h0001 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL wrap_0 got sel=%0d gnt=%h v=%b exp 0/0001/1", selec_a, gnt_a, valid_a);
    end
    total++;
    req_a = '0;
    tick();
    tick();
  endtask

  // ptr is 1 here; 0x0080 yields owner 7.
  task automatic test_reset_mid_grant();
    req_a = 16'h0080;
    tick();
    if (selec_a !== 4'd7 || gnt_a !== 16'h0080) begin
      bad++;
      $display("FAIL mid_pre got sel=%0d gnt=%h exp 7/0080", selec_a, gnt_a);
    end
    total++;
    #2;
    rst_n = 1'b0;
    #1;
    if (gnt_a !== 16'h0 || valid_a !== 1'b0 || selec_a !== 4'd0 || preempt_a !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got gnt=%h v=%b sel=%0d p=%b exp all 0", gnt_a, valid_a, selec_a, preempt_a);
    end
    total++;
    req_a = 16'h0081;
    #2;
    rst_n = 1'b1;
    tick();
    if (selec_a !== 4'd0 || gnt_a !== 16'h0001 || valid_a !== 1'b1) begin
      bad++;
      $display("FAIL mid_after got sel=%0d gnt=%h v=%b exp 0/0001/1", selec_a, gnt_a, valid_a);
    end
    total++;
    req_a = '0;
    tick();
    tick();
  endtask

  // MAX_HOLD=1: one-cycle grants, preempt only if req still high.
  task automatic test_max_hold_one();
    req_b = 4'b0010;
    tick();
    if (gnt_b !== 4'b0010 || selec_b !== 2'd1 || valid_b !== 1'b1) begin
      bad++;
      $display("FAIL mh1_grant got gnt=%b sel=%0d v=%b exp 0010/1/1", gnt_b, selec_b, valid_b);
    end
    total++;
    tick();
    if (valid_b !== 1'b0 || preempt_b !== 1'b1 || selec_b !== 2'd1) begin
      bad++;
      $display("FAIL mh1_preempt got v=%b p=%b sel=%0d exp 0/1/1", valid_b, preempt_b, selec_b);
    end
    total++;
    tick();
    if (gnt_b !== 4'b0010 || valid_b !== 1'b1 || preempt_b !== 1'b0) begin
      bad++;
      $display("FAIL mh1_regrant got gnt=%b v=%b p=%b exp 0010/1/0", gnt_b, valid_b, preempt_b);
    end
    total++;
    req_b = '0;
    tick();
    if (valid_b !== 1'b0 || preempt_b !== 1'b0) begin
      bad++;
      $display("FAIL mh1_release got v=%b p=%b exp 0/0", valid_b, preempt_b);
    end
    total++;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 16; i++) mux_in[i] = 8'hA0 + 8'(i);
    test_reset();
    test_single();
    test_preempt_rotation();
    test_wrap();
    test_reset_mid_grant();
    test_max_hold_one();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
